// File: rtl/vga_scan_gen_pkg.sv
// Shared 640x480@60 timing constants and helpers for the scan generator and the
// draw blocks that window on screen coordinates.
package vga_scan_gen_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int CLK_DIV   = 4;
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } scan_ctl_t;

  // Sync lines idle high, screen blanked.
  localparam scan_ctl_t CTL_IDLE = 3'b110;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_scan_gen_delay_line.sv
// Fixed-depth register chain with synchronous reset to a chosen value; every
// stage advances on every clock.
module delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: pixel-rate divider, h/v counters and sync/blank
// decode, with the decoded controls delayed to line up with pixel readers.
module vga_scan_gen #(
  parameter int H_DISPLAY = vga_scan_gen_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_scan_gen_pkg::H_FRONT,
  parameter int H_SYNC    = vga_scan_gen_pkg::H_SYNC,
  parameter int H_BACK    = vga_scan_gen_pkg::H_BACK,
  parameter int V_DISPLAY = vga_scan_gen_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_scan_gen_pkg::V_FRONT,
  parameter int V_SYNC    = vga_scan_gen_pkg::V_SYNC,
  parameter int V_BACK    = vga_scan_gen_pkg::V_BACK,
  parameter int CLK_DIV   = vga_scan_gen_pkg::CLK_DIV,
  parameter int PIPE      = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       p_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  import vga_scan_gen_pkg::*;

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             w_ptick;
  logic             w_h_end;
  logic             w_v_end;
  scan_ctl_t        w_raw;
  scan_ctl_t        w_out;

  assign w_ptick = (r_div == DIV_LAST);
  assign w_h_end = (r_h == H_LAST);
  assign w_v_end = (r_v == V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_ptick ? '0 : r_div + DIV_W'(1);
      if (w_ptick) begin
        r_h <= w_h_end ? '0 : r_h + 10'd1;
        if (w_h_end) r_v <= w_v_end ? '0 : r_v + 10'd1;
      end
    end
  end

  always_comb begin
    w_raw          = CTL_IDLE;
    w_raw.hsync    = ~in_window(r_h, HS_LO, HS_HI);
    w_raw.vsync    = ~in_window(r_v, VS_LO, VS_HI);
    w_raw.video_on = (r_h < H_VIS) && (r_v < V_VIS);
  end

  // One stage is always present so PIPE=0 still yields a registered output.
  delay_line #(
    .WIDTH  ($bits(scan_ctl_t)),
    .DEPTH  (PIPE + 1),
    .RST_VAL(CTL_IDLE)
  ) u_ctl_dly (
    .clk  (clk),
    .reset(reset),
    .i_d  (w_raw),
    .o_q  (w_out)
  );

  assign x          = r_h;
  assign y          = r_v;
  assign p_tick     = w_ptick & ~reset;
  assign frame_tick = w_ptick & w_h_end & w_v_end & ~reset;
  assign video_on   = w_out.video_on;
  assign hsync      = w_out.hsync;
  assign vsync      = w_out.vsync;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: a default 640x480 instance (PIPE=1) and a tiny-raster
// instance (PIPE=3) so whole frames fit in a short run.
module tb_vga_scan_gen;

  localparam int K_VON = 0, K_VOFF = 1, K_HFALL = 2, K_HRISE = 3;
  localparam int K_VSFALL = 4, K_VSRISE = 5, K_FT = 6, NK = 7;
  localparam int END_A = 6300;
  localparam int END_B = 962;

  typedef struct packed { int cyc; int x; int y; } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       pt_a, ft_a, von_a, hs_a, vs_a;
  logic       pt_b, ft_b, von_b, hs_b, vs_b;

  vga_scan_gen dut_a (
    .clk(clk), .reset(rst_a), .x(x_a), .y(y_a), .p_tick(pt_a),
    .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
  );

  vga_scan_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .PIPE(3)
  ) dut_b (
    .clk(clk), .reset(rst_b), .x(x_b), .y(y_b), .p_tick(pt_b),
    .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
  );

  int total = 0;
  int bad   = 0;

  pix_t        q_pix  [2][$];
  int          q_ev   [2][NK][$];
  logic [24:0] q_snap [2][$];

  int   cnt [2];
  bit   run [2];
  int   t_x0[2], y_x0[2], t_xd[2], y_xd[2], t_hs[2], y_hs[2];
  int   t_hf[2], t_vs[2], t_vf[2];
  int   px[2], py[2];
  logic pv[2], ph[2], pvs[2];

  always @(posedge clk) begin
    cnt[0] <= rst_a ? 0 : cnt[0] + 1;
    cnt[1] <= rst_b ? 0 : cnt[1] + 1;
  end

  function automatic string kname(input int k);
    case (k)
      K_VON:    return "video_rise";
      K_VOFF:   return "video_fall";
      K_HFALL:  return "hsync_fall";
      K_HRISE:  return "hsync_width";
      K_VSFALL: return "vsync_fall";
      K_VSRISE: return "vsync_width";
      default:  return "frame_tick";
    endcase
  endfunction

  task automatic ev_check(input int d, input int k, input int val);
    int e;
    total++;
    if (q_ev[d][k].size() == 0) begin
      bad++;
      $display("FAIL %s dut%0d: got=%0d want=none", kname(k), d, val);
    end else begin
      e = q_ev[d][k].pop_front();
      if (e != val) begin
        bad++;
        $display("FAIL %s dut%0d: got=%0d want=%0d", kname(k), d, val, e);
      end
    end
  endtask

  task automatic mon_step(input int d);
    int cx, cy, c;
    logic cp, cf, cv, ch, cvs, cr;
    logic [24:0] act, exp_v;
    pix_t p;
    cx  = d ? int'(x_b) : int'(x_a);
    cy  = d ? int'(y_b) : int'(y_a);
    cp  = d ? pt_b  : pt_a;
    cf  = d ? ft_b  : ft_a;
    cv  = d ? von_b : von_a;
    ch  = d ? hs_b  : hs_a;
    cvs = d ? vs_b  : vs_a;
    cr  = d ? rst_b : rst_a;
    c   = cnt[d];

    if (q_snap[d].size() > 0) begin
      exp_v = q_snap[d].pop_front();
      act   = {10'(cx), 10'(cy), cp, cf, cv, ch, cvs};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL reset_state dut%0d: got=%h want=%h", d, act, exp_v);
      end
    end

    // Markers: cycle (and line) at which the counters entered each region.
    if (cx != px[d] || cr) begin
      if (cx == 0) begin t_x0[d] = c; y_x0[d] = cy; end
      if (cx == (d ? 8 : 640)) begin t_xd[d] = c; y_xd[d] = cy; end
      if (cx == (d ? 10 : 656)) begin t_hs[d] = c; y_hs[d] = cy; end
    end
    if (cy != py[d] && cy == (d ? 7 : 490)) t_vs[d] = c;

    if (run[d]) begin
      if (cv && !pv[d]) ev_check(d, K_VON,  c - t_x0[d] + 1000 * y_x0[d]);
      if (!cv && pv[d]) ev_check(d, K_VOFF, c - t_xd[d] + 1000 * y_xd[d]);
      if (!ch && ph[d]) begin
        t_hf[d] = c;
        ev_check(d, K_HFALL, c - t_hs[d] + 1000 * y_hs[d]);
      end
      if (ch && !ph[d]) ev_check(d, K_HRISE, c - t_hf[d] + 1000 * y_hs[d]);
      if (!cvs && pvs[d]) begin
        t_vf[d] = c;
        ev_check(d, K_VSFALL, c - t_vs[d]);
      end
      if (cvs && !pvs[d]) ev_check(d, K_VSRISE, c - t_vf[d]);
      if (cf) ev_check(d, K_FT, c + 1);
      if (cp) begin
        total++;
        if (q_pix[d].size() == 0) begin
          bad++;
          $display("FAIL pix dut%0d: got cyc=%0d x=%0d y=%0d want none", d, c + 1, cx, cy);
        end else begin
          p = q_pix[d].pop_front();
          if (p.cyc != c + 1 || p.x != cx || p.y != cy) begin
            bad++;
            $display("FAIL pix dut%0d: got cyc=%0d x=%0d y=%0d want cyc=%0d x=%0d y=%0d",
                     d, c + 1, cx, cy, p.cyc, p.x, p.y);
          end
        end
      end
    end

    px[d] = cx; py[d] = cy; pv[d] = cv; ph[d] = ch; pvs[d] = cvs;
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 5'b00011};

  initial begin
    bit found;
    rst_a = 1'b1;
    rst_b = 1'b1;
    run[0] = 1'b0;
    run[1] = 1'b0;

    // Default raster: 4 clks/pixel, 800x525, PIPE=1 -> 2-clk control latency.
    for (int k = 0; k <= 1574; k++)
      q_pix[0].push_back('{cyc: 4 * (k + 1), x: k % 800, y: k / 800});
    for (int l = 0; l < 2; l++) begin
      q_ev[0][K_VON].push_back(2 + 1000 * l);
      q_ev[0][K_VOFF].push_back(2 + 1000 * l);
      q_ev[0][K_HFALL].push_back(2 + 1000 * l);
      q_ev[0][K_HRISE].push_back(384 + 1000 * l);
    end

    // Tiny raster: 2 clks/pixel, 16x10, PIPE=3 -> 4-clk latency, 320 clks/frame.
    for (int k = 0; k <= 480; k++)
      q_pix[1].push_back('{cyc: 2 * (k + 1), x: k % 16, y: (k / 16) % 10});
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 10; l++) begin
        if (l < 6) begin
          q_ev[1][K_VON].push_back(4 + 1000 * l);
          q_ev[1][K_VOFF].push_back(4 + 1000 * l);
        end
        q_ev[1][K_HFALL].push_back(4 + 1000 * l);
        q_ev[1][K_HRISE].push_back(6 + 1000 * l);
      end
      q_ev[1][K_VSFALL].push_back(4);
      q_ev[1][K_VSRISE].push_back(64);
      q_ev[1][K_FT].push_back(320 * (f + 1));
    end

    repeat (3) @(posedge clk);
    #2;
    q_snap[0].push_back(RST_VEC);
    q_snap[1].push_back(RST_VEC);
    @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    run[0] = 1'b1;
    run[1] = 1'b1;

    while (cnt[1] < END_B) begin @(posedge clk); #2; end
    #5;
    run[1] = 1'b0;

    // Mid-frame reset of the tiny raster inside the visible area.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #2;
      if (x_b == 10'd5 && y_b == 10'd3) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_5_3 dut1: got=not_reached want=reached");
    end
    rst_b = 1'b1;
    @(posedge clk);
    #2;
    q_snap[1].push_back(RST_VEC);
    rst_b = 1'b0;

    while (cnt[0] < END_A) begin @(posedge clk); #2; end
    #5;
    run[0] = 1'b0;
    @(posedge clk);
    #2;

    for (int d = 0; d < 2; d++) begin
      total++;
      if (q_pix[d].size() != 0) begin
        bad++;
        $display("FAIL pix_left dut%0d: got=%0d want=0", d, q_pix[d].size());
      end
      total++;
      if (q_snap[d].size() != 0) begin
        bad++;
        $display("FAIL snap_left dut%0d: got=%0d want=0", d, q_snap[d].size());
      end
      for (int k = 0; k < NK; k++) begin
        total++;
        if (q_ev[d][k].size() != 0) begin
          bad++;
          $display("FAIL %s_left dut%0d: got=%0d want=0", kname(k), d, q_ev[d][k].size());
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
